// File: rtl/arp_rx_pkg.sv
// -----------------------------------------------------------------------------
// arp_rx_pkg
// Constants and helpers shared by the ARP receive and transmit paths: EtherType,
// ARP header fields, opcodes, preamble/SFD bytes, the broadcast MAC, the FSM
// state encoding and byte-select helpers used when comparing a byte stream
// against wide fields.
// -----------------------------------------------------------------------------
package arp_rx_pkg;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] HD_TYPE        = 16'h0001;
  localparam logic [15:0] PROTOCOL_TYPE  = 16'h0800;
  localparam logic [7:0]  HW_ADDR_LEN    = 8'd6;
  localparam logic [7:0]  PROTO_ADDR_LEN = 8'd4;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [47:0] MAC_BCAST      = 48'hFF_FF_FF_FF_FF_FF;

  // One-hot receive FSM encoding.
  typedef enum logic [4:0] {
    st_idle     = 5'b00001,
    st_preamble = 5'b00010,
    st_eth_head = 5'b00100,
    st_arp_data = 5'b01000,
    st_rx_end   = 5'b10000
  } arp_rx_state_e;

  // Byte idx (0 = first on the wire, i.e. most significant) of a 48-bit MAC.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

  // Byte idx (0 = first on the wire) of a 32-bit IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ip[31:24];
      2'd1:    b = ip[23:16];
      2'd2:    b = ip[15:8];
      default: b = ip[7:0];
    endcase
    return b;
  endfunction

  // Expected fixed ARP header bytes 0..6: htype, ptype, hlen, plen, opcode MSB.
  function automatic logic [7:0] arp_fixed_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HD_TYPE[15:8];
      3'd1:    b = HD_TYPE[7:0];
      3'd2:    b = PROTOCOL_TYPE[15:8];
      3'd3:    b = PROTOCOL_TYPE[7:0];
      3'd4:    b = HW_ADDR_LEN;
      3'd5:    b = PROTO_ADDR_LEN;
      default: b = ARP_OP_REQ[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/arp_rx.sv
// -----------------------------------------------------------------------------
// arp_rx
// GMII ARP receiver. Parses preamble/SFD, the Ethernet header (destination MAC
// must be BOARD_MAC or broadcast, EtherType 0x0806) and the ARP payload
// (fixed header, opcode request/reply, sender MAC/IP, target IP == BOARD_IP).
// A valid frame produces a one-cycle arp_rx_done pulse together with updated
// src_mac / src_ip / arp_rx_type. The FCS is not checked.
//
// Ports
//   clk          GMII receive clock
//   rst          asynchronous active-high reset
//   gmii_rx_dv   receive data valid
//   gmii_rxd     receive byte
//   arp_rx_done  1-cycle pulse for an accepted ARP frame
//   arp_rx_type  0 = request, 1 = reply (held until the next arp_rx_done)
//   src_mac      sender MAC of the last accepted frame
//   src_ip       sender IP of the last accepted frame
//
// Build option
//   ARP_RX_IN_REG_EN  when defined, gmii_rx_dv/gmii_rxd pass through one
//                     register stage before the FSM (done latency 2 clk
//                     instead of 1).
// -----------------------------------------------------------------------------
module arp_rx
  import arp_rx_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  // ---------------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------------
  logic       rx_dv;
  logic [7:0] rxd;

`ifdef ARP_RX_IN_REG_EN
  logic       rx_dv_q;
  logic [7:0] rxd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_dv_q <= 1'b0;
      rxd_q   <= 8'h00;
    end else begin
      rx_dv_q <= gmii_rx_dv;
      rxd_q   <= gmii_rxd;
    end
  end

  assign rx_dv = rx_dv_q;
  assign rxd   = rxd_q;
`else
  assign rx_dv = gmii_rx_dv;
  assign rxd   = gmii_rxd;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arp_rx_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  // Destination MAC is accepted only if all six bytes match one candidate, so
  // each candidate keeps its own miss flag.
  logic          ucast_miss_q, ucast_miss_d;
  logic          bcast_miss_q, bcast_miss_d;
  // Set once dv has been seen low since reset; a frame still in flight when
  // reset is released must not be mistaken for a new one.
  logic          armed_q, armed_d;
  logic [47:0]   mac_shadow_q, mac_shadow_d;
  logic [31:0]   ip_shadow_q, ip_shadow_d;
  logic          type_shadow_q, type_shadow_d;
  logic          done_q, done_d;
  logic          type_q, type_d;
  logic [47:0]   src_mac_q, src_mac_d;
  logic [31:0]   src_ip_q, src_ip_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= st_idle;
      cnt_q         <= 5'd0;
      err_q         <= 1'b0;
      ucast_miss_q  <= 1'b0;
      bcast_miss_q  <= 1'b0;
      armed_q       <= 1'b0;
      mac_shadow_q  <= 48'd0;
      ip_shadow_q   <= 32'd0;
      type_shadow_q <= 1'b0;
      done_q        <= 1'b0;
      type_q        <= 1'b0;
      src_mac_q     <= 48'd0;
      src_ip_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      ucast_miss_q  <= ucast_miss_d;
      bcast_miss_q  <= bcast_miss_d;
      armed_q       <= armed_d;
      mac_shadow_q  <= mac_shadow_d;
      ip_shadow_q   <= ip_shadow_d;
      type_shadow_q <= type_shadow_d;
      done_q        <= done_d;
      type_q        <= type_d;
      src_mac_q     <= src_mac_d;
      src_ip_q      <= src_ip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    ucast_miss_d  = ucast_miss_q;
    bcast_miss_d  = bcast_miss_q;
    armed_d       = armed_q;
    mac_shadow_d  = mac_shadow_q;
    ip_shadow_d   = ip_shadow_q;
    type_shadow_d = type_shadow_q;
    done_d        = 1'b0;
    type_d        = type_q;
    src_mac_d     = src_mac_q;
    src_ip_d      = src_ip_q;
    cnt_d         = 5'd0;

    if (!rx_dv) begin
      // dv low ends whatever was in progress; outputs are left untouched.
      armed_d = 1'b1;
      state_d = st_idle;
    end else begin
      case (state_q)
        st_idle: begin
          if (armed_q && rxd == PREAMBLE_BYTE) state_d = st_preamble;
          else                                 state_d = st_rx_end;
        end

        st_preamble: begin
          err_d        = 1'b0;
          ucast_miss_d = 1'b0;
          bcast_miss_d = 1'b0;
          // The first 0x55 was consumed in idle: 6 more, then the SFD.
          if (cnt_q < 5'd6) begin
            if (rxd != PREAMBLE_BYTE) state_d = st_rx_end;
          end else begin
            if (rxd == SFD_BYTE) state_d = st_eth_head;
            else                 state_d = st_rx_end;
          end
        end

        st_eth_head: begin
          if (cnt_q <= 5'd5) begin
            if (rxd != mac_byte(BOARD_MAC, cnt_q[2:0])) ucast_miss_d = 1'b1;
            if (rxd != mac_byte(MAC_BCAST, cnt_q[2:0])) bcast_miss_d = 1'b1;
            if (cnt_q == 5'd5 && ucast_miss_d && bcast_miss_d) err_d = 1'b1;
          end
          if (cnt_q == 5'd12 && rxd != ETH_TYPE_ARP[15:8]) err_d = 1'b1;
          if (cnt_q == 5'd13) begin
            if (err_q || rxd != ETH_TYPE_ARP[7:0]) state_d = st_rx_end;
            else                                   state_d = st_arp_data;
          end
        end

        st_arp_data: begin
          if (cnt_q <= 5'd6) begin
            if (rxd != arp_fixed_byte(cnt_q[2:0])) state_d = st_rx_end;
          end else if (cnt_q == 5'd7) begin
            if (rxd == ARP_OP_REQ[7:0])        type_shadow_d = 1'b0;
            else if (rxd == ARP_OP_REPLY[7:0]) type_shadow_d = 1'b1;
            else                               state_d = st_rx_end;
          end else if (cnt_q <= 5'd13) begin
            mac_shadow_d = {mac_shadow_q[39:0], rxd};
          end else if (cnt_q <= 5'd17) begin
            ip_shadow_d = {ip_shadow_q[23:0], rxd};
          end else if (cnt_q >= 5'd24) begin
            // Bytes 24..27 map to target IP bytes 0..3 via the low counter bits.
            if (rxd != ip_byte(BOARD_IP, cnt_q[1:0])) begin
              state_d = st_rx_end;
            end else if (cnt_q == 5'd27) begin
              state_d   = st_rx_end;
              done_d    = 1'b1;
              type_d    = type_shadow_q;
              src_mac_d = mac_shadow_q;
              src_ip_d  = ip_shadow_q;
            end
          end
        end

        st_rx_end: state_d = st_rx_end;

        default: state_d = st_idle;
      endcase
    end

    // Counter restarts on every state change and only runs while parsing.
    if (state_d != state_q || state_q == st_idle || state_q == st_rx_end)
      cnt_d = 5'd0;
    else
      cnt_d = cnt_q + 5'd1;
  end

  assign arp_rx_done = done_q;
  assign arp_rx_type = type_q;
  assign src_mac     = src_mac_q;
  assign src_ip      = src_ip_q;

endmodule

// File: tb/tb_arp_rx.sv
// -----------------------------------------------------------------------------
// tb_arp_rx
// Self-checking bench for arp_rx: a table of directed frames, a mid-frame
// reset sequence and randomized frames scored against a frame-level model.
// -----------------------------------------------------------------------------
module tb_arp_rx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0A8010A;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
`ifdef ARP_RX_IN_REG_EN
  localparam int IN_LAT = 1;
`else
  localparam int IN_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  arp_rx dut (
    .clk         (clk),
    .rst         (rst),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -100;

  logic [7:0]  tx_q[$];
  logic        ref_type;
  logic [47:0] ref_mac;
  logic [31:0] ref_ip;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arp_rx_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic build_frame(input int pre_len, input logic [47:0] dst, input logic [15:0] etype,
                             input logic [7:0] op, input logic [47:0] smac, input logic [31:0] sip,
                             input logic [31:0] tip, input int trunc, input int pad);
    tx_q.delete();
    for (int i = 0; i < pre_len; i++) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) tx_q.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    tx_q.push_back(etype[15:8]);
    tx_q.push_back(etype[7:0]);
    tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    tx_q.push_back(8'h08); tx_q.push_back(8'h00);
    tx_q.push_back(8'h06); tx_q.push_back(8'h04);
    tx_q.push_back(8'h00); tx_q.push_back(op);
    for (int i = 5; i >= 0; i--) tx_q.push_back(smac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) tx_q.push_back(sip[8*i +: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) tx_q.push_back(tip[8*i +: 8]);
    for (int i = 0; i < pad; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    if (trunc > 0) while (tx_q.size() > trunc) void'(tx_q.pop_back());
  endtask

  // Frame-level reference: wire offsets 0..7 preamble/SFD, 8..21 Ethernet
  // header, 22..49 ARP payload (last ARP byte at offset 49).
  function automatic bit model_accept(output bit typ, output logic [47:0] mac, output logic [31:0] ip);
    logic [47:0] dst;
    logic [31:0] tgt;
    logic [7:0]  hdr [7];
    hdr = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00};
    typ = 1'b0; mac = '0; ip = '0; dst = '0; tgt = '0;
    if (tx_q.size() < 50) return 1'b0;
    for (int i = 0; i < 7; i++) if (tx_q[i] != 8'h55) return 1'b0;
    if (tx_q[7] != 8'hD5) return 1'b0;
    for (int i = 0; i < 6; i++) dst = {dst[39:0], tx_q[8+i]};
    if (dst != BOARD_MAC && dst != BCAST) return 1'b0;
    if (tx_q[20] != 8'h08 || tx_q[21] != 8'h06) return 1'b0;
    for (int i = 0; i < 7; i++) if (tx_q[22+i] != hdr[i]) return 1'b0;
    if (tx_q[29] != 8'h01 && tx_q[29] != 8'h02) return 1'b0;
    for (int i = 0; i < 4; i++) tgt = {tgt[23:0], tx_q[46+i]};
    if (tgt != BOARD_IP) return 1'b0;
    for (int i = 0; i < 6; i++) mac = {mac[39:0], tx_q[30+i]};
    for (int i = 0; i < 4; i++) ip = {ip[23:0], tx_q[36+i]};
    typ = (tx_q[29] == 8'h02);
    return 1'b1;
  endfunction

  task automatic drive_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = tx_q[i];
      if (i == 49) last_cyc = cyc;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int g = 0; g < n; g++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
    end
    #1;
  endtask

  task automatic send_frame(input int gap);
    done_cnt = 0;
    drive_range(0, tx_q.size());
    idle_cycles(gap);
  endtask

  task automatic verify(input string tag, input bit exp_done, input bit exp_type,
                        input logic [47:0] mac, input logic [31:0] ip);
    check({tag, ".done_count"}, 64'(done_cnt), {63'd0, exp_done});
    if (exp_done) begin
      check({tag, ".latency"}, 64'(done_cyc), 64'(last_cyc + 1 + IN_LAT));
      ref_type = exp_type;
      ref_mac  = mac;
      ref_ip   = ip;
    end
    check({tag, ".arp_rx_type"}, {63'd0, arp_rx_type}, {63'd0, ref_type});
    check({tag, ".src_mac"}, {16'd0, src_mac}, {16'd0, ref_mac});
    check({tag, ".src_ip"}, {32'd0, src_ip}, {32'd0, ref_ip});
    $display("%s: bytes=%0d exp_done=%0d pulses=%0d type=%0d src_mac=%h src_ip=%h",
             tag, tx_q.size(), exp_done, done_cnt, arp_rx_type, src_mac, src_ip);
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [15:0] etype;
    logic [7:0]  op;
    logic [31:0] tip;
    logic [47:0] smac;
    logic [31:0] sip;
    int          trunc;
    int          gap;
    bit          exp_done;
    bit          exp_type;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int          pre_len, sel, trunc, k, gap;
  logic [47:0] dst, smac;
  logic [15:0] etype;
  logic [7:0]  op;
  logic [31:0] tip, sip;
  bit          m_ok, m_typ;
  logic [47:0] m_mac;
  logic [31:0] m_ip;

  initial begin
    vecs[0]  = '{BCAST, 16'h0806, 8'h01, BOARD_IP, 48'h000A3501FEC0, 32'hC0A80166, 0, 3, 1'b1, 1'b0};
    vecs[1]  = '{BOARD_MAC, 16'h0806, 8'h02, BOARD_IP, 48'h0A0B0C0D0E0F, 32'hC0A80102, 0, 3, 1'b1, 1'b1};
    vecs[2]  = '{BCAST, 16'h0806, 8'h01, 32'hC0A8010B, 48'h112233445566, 32'hC0A80177, 0, 3, 1'b0, 1'b0};
    vecs[3]  = '{BOARD_MAC, 16'h0800, 8'h01, BOARD_IP, 48'h223344556677, 32'hC0A80178, 0, 1, 1'b0, 1'b0};
    vecs[4]  = '{BCAST, 16'h0806, 8'h01, BOARD_IP, 48'h020000000001, 32'hC0A80103, 0, 3, 1'b1, 1'b0};
    vecs[5]  = '{BCAST, 16'h0806, 8'h02, BOARD_IP, 48'h334455667788, 32'hC0A80179, 43, 1, 1'b0, 1'b0};
    vecs[6]  = '{BOARD_MAC, 16'h0806, 8'h02, BOARD_IP, 48'h020000000002, 32'hC0A80104, 0, 3, 1'b1, 1'b1};
    vecs[7]  = '{BCAST, 16'h0806, 8'h03, BOARD_IP, 48'h445566778899, 32'hC0A8017A, 0, 3, 1'b0, 1'b0};
    vecs[8]  = '{48'h001122334456, 16'h0806, 8'h01, BOARD_IP, 48'h5566778899AA, 32'hC0A8017B, 0, 3, 1'b0, 1'b0};
    vecs[9]  = '{48'h0011223344FF, 16'h0806, 8'h01, BOARD_IP, 48'h66778899AABB, 32'hC0A8017C, 0, 3, 1'b0, 1'b0};
    vecs[10] = '{BCAST, 16'h0806, 8'h01, BOARD_IP, 48'h020000000003, 32'hC0A80105, 50, 3, 1'b1, 1'b0};

    rst = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    ref_type = 1'b0; ref_mac = '0; ref_ip = '0;
    repeat (3) @(negedge clk);
    check("reset.arp_rx_done", {63'd0, arp_rx_done}, 64'd0);
    check("reset.arp_rx_type", {63'd0, arp_rx_type}, 64'd0);
    check("reset.src_mac", {16'd0, src_mac}, 64'd0);
    check("reset.src_ip", {32'd0, src_ip}, 64'd0);
    rst = 1'b0;
    idle_cycles(3);

    // Directed table
    for (int v = 0; v < NV; v++) begin
      build_frame(7, vecs[v].dst, vecs[v].etype, vecs[v].op, vecs[v].smac, vecs[v].sip,
                  vecs[v].tip, vecs[v].trunc, 6);
      send_frame(vecs[v].gap);
      verify($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_type, vecs[v].smac, vecs[v].sip);
    end

    // Reset pulsed while inside the ARP payload; dv stays high through the
    // rest of that frame and a complete valid frame right behind it.
    build_frame(7, BCAST, 16'h0806, 8'h02, 48'h0CDEADBEEF01, 32'hC0A801AA, BOARD_IP, 0, 4);
    done_cnt = 0;
    drive_range(0, 33);
    #2 rst = 1'b1;
    #1;
    check("midrst.async.arp_rx_done", {63'd0, arp_rx_done}, 64'd0);
    check("midrst.async.arp_rx_type", {63'd0, arp_rx_type}, 64'd0);
    check("midrst.async.src_mac", {16'd0, src_mac}, 64'd0);
    check("midrst.async.src_ip", {32'd0, src_ip}, 64'd0);
    drive_range(33, 35);
    #2 rst = 1'b0;
    ref_type = 1'b0; ref_mac = '0; ref_ip = '0;
    drive_range(35, tx_q.size());
    build_frame(7, BCAST, 16'h0806, 8'h01, 48'h0CDEADBEEF02, 32'hC0A801AB, BOARD_IP, 0, 4);
    drive_range(0, tx_q.size());
    idle_cycles(3);
    verify("midrst.no_dv_low", 1'b0, 1'b0, 48'd0, 32'd0);
    build_frame(7, BOARD_MAC, 16'h0806, 8'h01, 48'h0CDEADBEEF03, 32'hC0A801AC, BOARD_IP, 0, 4);
    send_frame(3);
    verify("midrst.next_frame", 1'b1, 1'b0, 48'h0CDEADBEEF03, 32'hC0A801AC);

    // Randomized frames against the model
    for (int n = 0; n < 60; n++) begin
      pre_len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 8)) : 7;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       dst = BOARD_MAC;
        1:       dst = BCAST;
        2:       dst = {16'h0200, 32'($urandom)};
        default: dst = {BOARD_MAC[47:8], 8'hFF};
      endcase
      etype = ($urandom_range(0, 4) == 0) ? 16'h0800 : 16'h0806;
      op    = 8'($urandom_range(0, 3));
      tip   = ($urandom_range(0, 3) == 0) ? (BOARD_IP ^ (32'd1 << $urandom_range(0, 31))) : BOARD_IP;
      smac  = {16'($urandom), 32'($urandom)};
      sip   = 32'($urandom);
      trunc = ($urandom_range(0, 6) == 0) ? int'($urandom_range(20, 52)) : 0;
      build_frame(pre_len, dst, etype, op, smac, sip, tip, trunc, int'($urandom_range(2, 8)));
      if ($urandom_range(0, 9) == 0) begin
        k = int'($urandom_range(22, 29));
        if (k < tx_q.size()) tx_q[k] = tx_q[k] ^ 8'($urandom_range(1, 255));
      end
      m_ok = model_accept(m_typ, m_mac, m_ip);
      gap = int'($urandom_range(3, 5));
      send_frame(gap);
      verify($sformatf("rand%0d", n), m_ok, m_typ, m_mac, m_ip);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
